// File: rtl/hamm_seq.sv
`default_nettype none
// ============================================================================
// hamm_seq : sequential Hamming weight / distance, K bits per clock
// Rev 1.0
// ============================================================================
module hamm_seq #(
   parameter int N = 32,
   parameter int K = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          mode_i,
   input  logic [N-1:0]  a_i,
   input  logic [N-1:0]  b_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [CW-1:0] count_o
);

   localparam int C   = N / K;
   localparam int CHW = (C > 1) ? $clog2(C) : 1;
   localparam int PW  = $clog2(K + 1);

   generate
      if ((N < 2) || (K < 1) || (K > N) || ((N % K) != 0)) begin : g_param_check
         $error("hamm_seq: need N >= 2, 1 <= K <= N and N divisible by K");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   shift_q, shift_d;
   logic [CW-1:0]  acc_q, acc_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CHW-1:0] chunk_q, chunk_d;
   logic [PW-1:0]  chunk_pop;
   logic [CW-1:0]  sum;
   logic           last_chunk;

   // Popcount of the K low bits of the shift register; the only adder tree.
   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < K; i++) begin
         chunk_pop = chunk_pop + PW'(shift_q[i]);
      end
   end

   assign sum        = acc_q + CW'(chunk_pop);
   assign last_chunk = (chunk_q == CHW'(C - 1));

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      chunk_d = chunk_q;
      count_d = count_q;
      case (state_q)
         S_RUN: begin
            acc_d   = sum;
            shift_d = shift_q >> K;
            chunk_d = chunk_q + 1'b1;
            if (last_chunk) begin
               count_d = sum;
               state_d = S_DONE;
            end
         end
         default: begin
            // IDLE and DONE both accept a new request (DONE gives back-to-back).
            if (start_i) begin
               shift_d = a_i ^ (mode_i ? b_i : '0);
               acc_d   = '0;
               chunk_d = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         acc_q   <= '0;
         chunk_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         chunk_q <= chunk_d;
         count_q <= count_d;
      end
   end

   assign busy_o  = (state_q == S_RUN);
   assign done_o  = (state_q == S_DONE);
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_hamm_seq.sv
`default_nettype none
// ============================================================================
// tb_hamm_seq : self-checking bench for hamm_seq (directed table + random sweep)
// Rev 1.0
// ============================================================================
module tb_hamm_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance, N=32 K=8
   logic        start = 1'b0, mode = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [5:0]  count;

   hamm_seq #(.N(32), .K(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode),
      .a_i(a), .b_i(b), .busy_o(busy), .done_o(done), .count_o(count));

   // parameter sweep instances sharing one stimulus
   logic        sw_start = 1'b0, sw_mode = 1'b0;
   logic [63:0] sw_a = '0, sw_b = '0;
   logic        sw_busy [4];
   logic        sw_done [4];
   logic [5:0]  c0, c1;
   logic [4:0]  c2;
   logic [6:0]  c3;
   logic [6:0]  sw_cnt [4];
   assign sw_cnt[0] = 7'(c0);
   assign sw_cnt[1] = 7'(c1);
   assign sw_cnt[2] = 7'(c2);
   assign sw_cnt[3] = c3;

   hamm_seq #(.N(32), .K(1)) u_s0 (
      .clk(clk), .rst_n(rst_n), .start_i(sw_start), .mode_i(sw_mode),
      .a_i(sw_a[31:0]), .b_i(sw_b[31:0]), .busy_o(sw_busy[0]), .done_o(sw_done[0]), .count_o(c0));
   hamm_seq #(.N(32), .K(32)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start_i(sw_start), .mode_i(sw_mode),
      .a_i(sw_a[31:0]), .b_i(sw_b[31:0]), .busy_o(sw_busy[1]), .done_o(sw_done[1]), .count_o(c1));
   hamm_seq #(.N(16), .K(4)) u_s2 (
      .clk(clk), .rst_n(rst_n), .start_i(sw_start), .mode_i(sw_mode),
      .a_i(sw_a[15:0]), .b_i(sw_b[15:0]), .busy_o(sw_busy[2]), .done_o(sw_done[2]), .count_o(c2));
   hamm_seq #(.N(64), .K(8)) u_s3 (
      .clk(clk), .rst_n(rst_n), .start_i(sw_start), .mode_i(sw_mode),
      .a_i(sw_a), .b_i(sw_b), .busy_o(sw_busy[3]), .done_o(sw_done[3]), .count_o(c3));

   int total = 0;
   int bad   = 0;
   int last_count = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Reference: count the ones of the selected word over its n low bits.
   function automatic int ref_count(input logic [63:0] av, input logic [63:0] bv,
                                    input logic m, input int n);
      logic [63:0] v;
      int s;
      v = m ? (av ^ bv) : av;
      s = 0;
      for (int i = 0; i < n; i++) s += int'(v[i]);
      return s;
   endfunction

   // One request on the main instance; operands are scrambled after acceptance.
   task automatic op_main(input logic m, input logic [31:0] av, input logic [31:0] bv,
                          input int exp, input string nm);
      int  busy_n, hold_err;
      bit  seen;
      @(negedge clk);
      start = 1'b1; mode = m; a = av; b = bv;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; mode = 1'($urandom);
      busy_n = 0; hold_err = 0; seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_n++;
         if (busy && (int'(count) != last_count)) hold_err++;
         @(negedge clk);
      end
      check({nm, "_done_seen"}, 64'(seen), 64'd1);
      check({nm, "_busy_cycles"}, 64'(busy_n), 64'd4);
      check({nm, "_count"}, 64'(count), 64'(exp));
      check({nm, "_count_hold"}, 64'(hold_err), 64'd0);
      check({nm, "_busy_with_done"}, 64'(busy), 64'd0);
      @(negedge clk);
      check({nm, "_done_one_cycle"}, 64'(done), 64'd0);
      last_count = exp;
   endtask

   typedef struct {
      logic        m;
      logic [31:0] av;
      logic [31:0] bv;
      int          exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int done_n, done_at, cnt_at;
      int dq_at [2];
      int dq_cnt [2];
      int bd_err;
      int sw_at [4];
      int sw_val [4];
      int sw_c [4];
      int sw_n [4];
      logic [63:0] ra, rb;
      logic rm;

      vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32};
      vecs[1] = '{1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32};
      vecs[2] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 0};
      vecs[3] = '{1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 2};
      vecs[4] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 0};
      vecs[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32};
      vecs[6] = '{1'b1, 32'hFFFF_0000, 32'hFF00_FF00, 16};
      vecs[7] = '{1'b0, 32'h0100_0080, 32'h0000_0000, 2};
      sw_c = '{32, 1, 4, 8};
      sw_n = '{32, 32, 16, 64};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) op_main(vecs[i].m, vecs[i].av, vecs[i].bv, vecs[i].exp, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         ra = {32'h0, $urandom};
         rb = {32'h0, $urandom};
         rm = 1'($urandom);
         op_main(rm, ra[31:0], rb[31:0], ref_count(ra, rb, rm, 32), $sformatf("rnd%0d", i));
      end

      // start and operand changes during RUN must be ignored
      @(negedge clk);
      start = 1'b1; mode = 1'b0; a = 32'h0000_00FF; b = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 1'b0;
      done_n = 0; done_at = -1; cnt_at = -1;
      for (int idx = 0; idx < 12; idx++) begin
         if (done) begin
            done_n++;
            if (done_at < 0) begin done_at = idx; cnt_at = int'(count); end
         end
         if (idx == 1) begin start = 1'b1; a = 32'h0; mode = 1'b1; end
         if (idx == 2) start = 1'b0;
         @(negedge clk);
      end
      check("intf_done_pulses", 64'(done_n), 64'd1);
      check("intf_done_edge", 64'(done_at), 64'd4);
      check("intf_count", 64'(cnt_at), 64'd8);

      // back-to-back with start held for ten edges
      start = 1'b1; mode = 1'b0; a = 32'h0000_000F;
      @(negedge clk);
      done_n = 0; bd_err = 0;
      dq_at = '{-1, -1}; dq_cnt = '{-1, -1};
      for (int idx = 0; idx < 15; idx++) begin
         if (done) begin
            if (done_n < 2) begin dq_at[done_n] = idx; dq_cnt[done_n] = int'(count); end
            done_n++;
         end
         if (idx <= 9 && (busy == done)) bd_err++;
         if (idx == 9) start = 1'b0;
         @(negedge clk);
      end
      check("b2b_done_pulses", 64'(done_n), 64'd2);
      check("b2b_first_edge", 64'(dq_at[0]), 64'd4);
      check("b2b_second_edge", 64'(dq_at[1]), 64'd9);
      check("b2b_first_count", 64'(dq_cnt[0]), 64'd4);
      check("b2b_second_count", 64'(dq_cnt[1]), 64'd4);
      check("b2b_busy_vs_done", 64'(bd_err), 64'd0);

      // asynchronous reset in the third RUN cycle
      start = 1'b1; a = 32'hFFFF_FFFF; mode = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("prerst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_count", 64'(count), 64'd0);
      done_n = 0;
      for (int idx = 0; idx < 6; idx++) begin
         @(negedge clk);
         if (idx == 2) rst_n = 1'b1;
         if (done) done_n++;
      end
      check("midrst_no_done", 64'(done_n), 64'd0);
      last_count = 0;
      op_main(1'b0, 32'h0000_0007, 32'h0, 3, "post_rst");

      // parameter sweep: done after exactly C edges, count matches reference
      for (int tr = 0; tr < 12; tr++) begin
         @(negedge clk);
         sw_start = 1'b1;
         sw_mode = 1'($urandom);
         sw_a = {$urandom, $urandom};
         sw_b = {$urandom, $urandom};
         ra = sw_a; rb = sw_b; rm = sw_mode;
         @(negedge clk);
         sw_start = 1'b0;
         sw_a = {$urandom, $urandom};
         sw_b = {$urandom, $urandom};
         sw_mode = ~sw_mode;
         sw_at = '{-1, -1, -1, -1};
         sw_val = '{-1, -1, -1, -1};
         for (int idx = 0; idx < 40; idx++) begin
            for (int j = 0; j < 4; j++) begin
               if (sw_done[j] && sw_at[j] < 0) begin
                  sw_at[j] = idx;
                  sw_val[j] = int'(sw_cnt[j]);
               end
            end
            @(negedge clk);
         end
         for (int j = 0; j < 4; j++) begin
            check($sformatf("sweep%0d_cfg%0d_latency", tr, j), 64'(sw_at[j]), 64'(sw_c[j]));
            check($sformatf("sweep%0d_cfg%0d_count", tr, j), 64'(sw_val[j]),
                  64'(ref_count(ra, rb, rm, sw_n[j])));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
